// File: rtl/io_bus_scheduler_if.sv
// Device-side and memory-side signal bundle for io_bus_scheduler.
// The slave modport is the scheduler's view; master drives requests and memory responses.
interface io_bus_scheduler_if #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned IO_COUNT  = 2
);
  logic [IO_COUNT-1:0]           req_i;
  logic [IO_COUNT-1:0]           we_i;
  logic [IO_COUNT*WORD_SIZE-1:0] addr_i;
  logic [IO_COUNT*WORD_SIZE-1:0] wdata_i;
  logic [IO_COUNT-1:0]           done_o;
  logic [IO_COUNT-1:0]           err_o;
  logic [WORD_SIZE-1:0]          rdata_o;
  logic                          busy_o;
  logic                          mem_req_o;
  logic                          mem_we_o;
  logic [WORD_SIZE-1:0]          mem_addr_o;
  logic [WORD_SIZE-1:0]          mem_wdata_o;
  logic                          mem_ack_i;
  logic [WORD_SIZE-1:0]          mem_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    output done_o, err_o, rdata_o, busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
    input  done_o, err_o, rdata_o, busy_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/io_bus_scheduler.sv
// Round-robin arbiter sharing one I/O memory port among IO_COUNT devices,
// one transaction at a time, with an ACCESS timeout so a dead port cannot starve devices.
module io_bus_scheduler #(
  parameter int unsigned WORD_SIZE = 64,
  parameter int unsigned IO_COUNT  = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input logic               clk,
  input logic               rst,
  io_bus_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (IO_COUNT > 1) ? $clog2(IO_COUNT) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IO_COUNT-1:0]  done_q, done_d;
  logic [IO_COUNT-1:0]  err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;

  logic [WORD_SIZE-1:0] addr_arr  [IO_COUNT];
  logic [WORD_SIZE-1:0] wdata_arr [IO_COUNT];
  logic [IDX_W-1:0]     win;
  logic                 found;
  int unsigned          idx;

  for (genvar g = 0; g < IO_COUNT; g++) begin : g_unpack
    assign addr_arr[g]  = bus.addr_i[g*WORD_SIZE +: WORD_SIZE];
    assign wdata_arr[g] = bus.wdata_i[g*WORD_SIZE +: WORD_SIZE];
  end

  // First requester scanning upward from last_gnt+1, wrapping modulo IO_COUNT.
  always_comb begin
    found = 1'b0;
    win   = last_gnt_q;
    idx   = 0;
    for (int unsigned off = 1; off <= IO_COUNT; off++) begin
      idx = 32'(last_gnt_q) + off;
      if (idx >= IO_COUNT) idx = idx - IO_COUNT;
      if (!found && bus.req_i[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    done_d     = '0;
    err_d      = '0;
    busy_d     = busy_q;
    mem_req_d  = mem_req_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = win;
          last_gnt_d = win;
          we_d       = bus.we_i[win];
          addr_d     = addr_arr[win];
          wdata_d    = wdata_arr[win];
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Ack has priority over a coincident timeout expiry.
        if (bus.mem_ack_i) begin
          rdata_d       = we_q ? '0 : bus.mem_rdata_i;
          mem_req_d     = 1'b0;
          done_d[gnt_q] = 1'b1;
          state_d       = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d       = '0;
          mem_req_d     = 1'b0;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_gnt_q <= IDX_W'(IO_COUNT - 1);
      gnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      mem_req_q  <= mem_req_d;
    end
  end

  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
endmodule

// File: tb/tb_io_bus_scheduler.sv
// Directed bench for io_bus_scheduler: expected completions are queued when the ack
// (or timeout) is driven and popped when done_o appears.
module tb_io_bus_scheduler;
  localparam int unsigned W  = 64;
  localparam int unsigned N  = 2;
  localparam int unsigned TO = 4;

  typedef struct {
    logic [N-1:0] done;
    logic [N-1:0] err;
    logic [W-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  io_bus_scheduler_if #(.WORD_SIZE(W), .IO_COUNT(N)) bus ();

  io_bus_scheduler #(.WORD_SIZE(W), .IO_COUNT(N), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] addr_v  [N];
  logic [W-1:0] wdata_v [N];
  logic [N-1:0] req_v;
  logic [N-1:0] we_v;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.req_i   = req_v;
    bus.we_i    = we_v;
    bus.addr_i  = {addr_v[1], addr_v[0]};
    bus.wdata_i = {wdata_v[1], wdata_v[0]};
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_v = '0;
    we_v  = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    drive();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Starts from the negedge before the grant edge; returns in the RESP cycle.
  task automatic run_txn(input int dev, input int ack_cyc, input logic [W-1:0] rd, input bit disturb);
    logic         we;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    exp_t         e;
    we = we_v[dev];
    a  = addr_v[dev];
    wd = wdata_v[dev];
    tick();
    for (int c = 1; c <= int'(TO); c++) begin
      chk("mem_req_o", 64'(bus.mem_req_o), 64'(1));
      chk("mem_we_o", 64'(bus.mem_we_o), 64'(we));
      chk("mem_addr_o", bus.mem_addr_o, a);
      chk("mem_wdata_o", bus.mem_wdata_o, wd);
      chk("busy_o_access", 64'(bus.busy_o), 64'(1));
      chk("done_o_access", 64'(bus.done_o), 64'(0));
      if (disturb && c == 1) begin
        req_v[dev]   = 1'b0;
        addr_v[dev]  = 64'h999;
        wdata_v[dev] = ~wd;
        drive();
      end
      e.done = N'(1) << dev;
      if (c == ack_cyc) begin
        e.err   = '0;
        e.rdata = we ? '0 : rd;
        sb.push_back(e);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rd;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 64'hBAD0_BAD0;
        break;
      end
      if (c == int'(TO)) begin
        e.err   = e.done;
        e.rdata = '0;
        sb.push_back(e);
      end
      tick();
    end
    chk("done_o_present", 64'(bus.done_o != '0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("done_o", 64'(bus.done_o), 64'(e.done));
      chk("err_o", 64'(bus.err_o), 64'(e.err));
      chk("rdata_o", bus.rdata_o, e.rdata);
    end
    chk("mem_req_o_resp", 64'(bus.mem_req_o), 64'(0));
    chk("busy_o_resp", 64'(bus.busy_o), 64'(1));
  endtask

  initial begin
    do_reset();
    chk("rst_done_o", 64'(bus.done_o), 64'(0));
    chk("rst_err_o", 64'(bus.err_o), 64'(0));
    chk("rst_rdata_o", bus.rdata_o, 64'(0));
    chk("rst_busy_o", 64'(bus.busy_o), 64'(0));
    chk("rst_mem_req_o", 64'(bus.mem_req_o), 64'(0));
    chk("rst_mem_addr_o", bus.mem_addr_o, 64'(0));

    // Single read from dev0, ack in the third ACCESS cycle.
    addr_v[0] = 64'h100;
    req_v     = 2'b01;
    drive();
    run_txn(0, 3, 64'hDEAD, 1'b0);
    req_v = 2'b00;
    drive();
    tick();
    chk("t1_busy_o_idle", 64'(bus.busy_o), 64'(0));
    chk("t1_done_o_idle", 64'(bus.done_o), 64'(0));

    // Both devices requesting continuously: grants alternate starting at dev0.
    do_reset();
    addr_v[0]  = 64'h200;
    addr_v[1]  = 64'h300;
    wdata_v[1] = 64'h77;
    we_v       = 2'b10;
    req_v      = 2'b11;
    drive();
    run_txn(0, 1, 64'hA1, 1'b0);
    tick();
    chk("t2_busy_o_gap", 64'(bus.busy_o), 64'(0));
    run_txn(1, 1, 64'hA2, 1'b0);
    tick();
    run_txn(0, 1, 64'hA3, 1'b0);
    req_v = 2'b00;
    drive();
    tick();

    // Dev1 write with no ack: times out after TO cycles.
    we_v       = 2'b10;
    addr_v[1]  = 64'h20;
    wdata_v[1] = 64'h41;
    req_v      = 2'b10;
    drive();
    run_txn(1, 0, 64'h0, 1'b0);
    req_v = 2'b00;
    drive();
    tick();

    // Ack on the expiry cycle wins over the timeout.
    we_v      = 2'b00;
    addr_v[0] = 64'h400;
    req_v     = 2'b01;
    drive();
    run_txn(0, int'(TO), 64'hBEEF, 1'b0);
    req_v = 2'b00;
    drive();
    tick();

    // Stray ack while idle.
    bus.mem_ack_i   = 1'b1;
    bus.mem_rdata_i = 64'h123;
    tick();
    bus.mem_ack_i = 1'b0;
    chk("t4_idle_ack_done_o", 64'(bus.done_o), 64'(0));
    chk("t4_idle_ack_busy_o", 64'(bus.busy_o), 64'(0));
    chk("t4_idle_ack_mem_req_o", 64'(bus.mem_req_o), 64'(0));
    tick();
    chk("t4_idle_ack_done_o_2", 64'(bus.done_o), 64'(0));

    // Asynchronous reset in the middle of ACCESS.
    addr_v[1] = 64'h500;
    req_v     = 2'b10;
    drive();
    tick();
    chk("t5_mem_req_o_pre", 64'(bus.mem_req_o), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("t5_mem_req_o_async", 64'(bus.mem_req_o), 64'(0));
    chk("t5_busy_o_async", 64'(bus.busy_o), 64'(0));
    tick();
    chk("t5_done_o_rst", 64'(bus.done_o), 64'(0));
    tick();
    rst       = 1'b0;
    addr_v[0] = 64'h600;
    req_v     = 2'b11;
    drive();
    run_txn(0, 1, 64'h55, 1'b0);
    req_v = 2'b00;
    drive();
    tick();

    // Dev0 drops req and changes addr after the latch.
    addr_v[0]  = 64'h100;
    wdata_v[0] = 64'h0;
    req_v      = 2'b01;
    drive();
    run_txn(0, 2, 64'hC0DE, 1'b1);
    tick();
    chk("t6_busy_o_idle", 64'(bus.busy_o), 64'(0));
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
